oddeven_sort_ctrl: RTL and testbench
====================================

ODDEVEN_SORT_CTRL -- requirements
Module: oddeven_sort_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, element data width in bits.
REQ-002 SHALL have parameter N, default 16, elements per frame; power of two, N >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_data holds a valid element.
REQ-006 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-007 SHALL have port in_data  input  W  unsigned input element.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid sorted element.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 SHALL have port out_data  output  W  sorted element, ascending within frame.
REQ-011 SHALL have port out_last  output  1  high with the final (largest) element of a frame.
REQ-012 SHALL have port frame_cnt  output  16  completed frames count, wraps at 2^16.

Function
REQ-013 SHALL implement FSM with states LOAD, SORT, DRAIN; element index cnt of width log2(N).
REQ-014 LOAD: in_ready=1, out_valid=0; each cycle with in_valid=1 writes in_data to buf[cnt], cnt increments.
REQ-015 LOAD: acceptance with cnt=N-1 SHALL transition to SORT; in_valid gaps SHALL stall without loss.
REQ-016 SORT: lasts exactly one cycle; in_ready=0, out_valid=0; buf drives oddeven_N combinationally, its outputs are captured into res[0..N-1]; cnt cleared; next state DRAIN.
REQ-017 DRAIN: in_ready=0, out_valid=1, out_data=res[cnt], out_last=(cnt==N-1).
REQ-018 DRAIN: transfer occurs when out_valid=1 and out_ready=1; cnt increments on transfer.
REQ-019 DRAIN: transfer with out_last=1 SHALL clear cnt, increment frame_cnt, return to LOAD.
REQ-020 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Latency: last input accepted in cycle t -> out_valid first high in cycle t+2 (sampled at edge t+2).
REQ-022 No overlap: no input accepted from SORT entry until the frame's final output transfer; next frame's first element may be accepted the cycle after that transfer.
REQ-023 Ordering: res[0] smallest, res[N-1] largest, unsigned compare; duplicates SHALL all be emitted (multiset preserved).
REQ-024 When not in DRAIN, out_data SHALL be 0 and out_last SHALL be 0.
REQ-025 frame_cnt 0xFFFF + 1 SHALL wrap to 0x0000.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state LOAD, cnt=0, frame_cnt=0, in_ready=1, out_valid=0, out_data=0, out_last=0.
REQ-027 buf and res contents need not be reset; they SHALL never be visible on out_data outside DRAIN.
REQ-028 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial frame; no output of it appears after reset.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (LOAD, SORT, DRAIN) and default W/N constants.
REQ-030 SHALL instantiate the existing oddeven_N sorter as its single sub-module, parameterized with W and N, unmodified.
REQ-031 buf and res SHALL be flip-flop arrays of N x W; no memory macros.

Verification
REQ-032 Load 16,15,...,1 back-to-back, out_ready=1 -> outputs 1..16, out_last with 16, first out_valid two cycles after last input, frame_cnt=1.
REQ-033 Load l%8 for l=0..15 -> outputs 0,0,1,1,...,7,7; out_last with second 7.
REQ-034 Load 0..15 with in_valid gaps every other cycle, out_ready toggling 1/0 -> 0..15 in order, out_data stable during every stall, in_ready=0 throughout SORT/DRAIN.
REQ-035 Four frames of $random data with scoreboard model -> each frame ascending, matches reference sort, frame_cnt=4; also preload frame_cnt=0xFFFF via 65536 frames (or forced) -> wraps to 0.
REQ-036 Assert rst_n=0 after 7 elements loaded, then load 16 new elements -> only new frame emitted, sorted, frame_cnt=1.
REQ-037 Assert rst_n=0 in DRAIN after 5 transfers -> out_valid=0 next cycle, in_ready=1, frame_cnt=0.

Source files
------------

// File: rtl/oddeven_sort_ctrl_pkg.sv
// Shared definitions for the odd-even frame sorter: FSM encoding and default sizes.
package oddeven_sort_ctrl_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/oddeven_sort_ctrl_oddeven.sv
// Combinational odd-even transposition sorter: N alternating compare-exchange
// stages, ascending unsigned order, element i at bits [i*W +: W].
module oddeven_N #(
  parameter int W = 8,
  parameter int N = 16
) (
  input  logic [N*W-1:0] in_data,
  output logic [N*W-1:0] out_data
);

  logic [W-1:0] v [N];
  logic [W-1:0] tmp;

  always_comb begin
    tmp = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = in_data[i*W +: W];
    end
    // N alternating even/odd phases are enough to sort any N-element input.
    for (int s = 0; s < N; s++) begin
      for (int i = s % 2; i + 1 < N; i += 2) begin
        if (v[i] > v[i+1]) begin
          tmp    = v[i];
          v[i]   = v[i+1];
          v[i+1] = tmp;
        end
      end
    end
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[i*W +: W] = v[i];
    end
  end

endmodule

// File: rtl/oddeven_sort_ctrl.sv
// Frame sorter controller: loads N elements, sorts them in one cycle through
// oddeven_N, then streams them out ascending with valid/ready handshake.
module oddeven_sort_ctrl
  import oddeven_sort_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [15:0]  frame_cnt
);

  localparam int CW = $clog2(N);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic [W-1:0]    data_buf [N];
  logic [W-1:0]    res [N];
  logic [N*W-1:0]  sort_in;
  logic [N*W-1:0]  sort_out;
  logic            last_idx;
  logic            load_fire;
  logic            drain_fire;

  assign last_idx   = (cnt_reg == CW'(N - 1));
  assign load_fire  = (state_reg == ST_LOAD) && in_valid;
  assign drain_fire = (state_reg == ST_DRAIN) && out_ready;
  assign frame_cnt  = frame_cnt_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_last       = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_next = cnt_reg + 1'b1;
          if (last_idx) begin
            state_next = ST_SORT;
          end
        end
      end
      ST_SORT: begin
        cnt_next   = '0;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = res[cnt_reg];
        out_last  = last_idx;
        if (out_ready) begin
          cnt_next = cnt_reg + 1'b1;
          if (last_idx) begin
            cnt_next       = '0;
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = ST_LOAD;
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_LOAD;
      cnt_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Storage arrays are never reset; out_data is masked outside DRAIN instead.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      assign sort_in[gi*W +: W] = data_buf[gi];

      always_ff @(posedge clk) begin
        if (load_fire && (cnt_reg == CW'(gi))) begin
          data_buf[gi] <= in_data;
        end
        if (state_reg == ST_SORT) begin
          res[gi] <= sort_out[gi*W +: W];
        end
      end
    end
  endgenerate

  oddeven_N #(
    .W (W),
    .N (N)
  ) u_sorter (
    .in_data  (sort_in),
    .out_data (sort_out)
  );

endmodule

// File: tb/tb_oddeven_sort_ctrl.sv
// Directed bench for oddeven_sort_ctrl: load/sort/drain frames, stalls, resets, counter wrap.
module tb_oddeven_sort_ctrl;

  localparam int W = 8;
  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [15:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fc   = 0;

  logic [W-1:0] vec [N];
  logic [W-1:0] exp_vec [N];

  oddeven_sort_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic load_frame(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      check("in_ready_load", in_ready, 1);
      step();
      if (gaps && i < count - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hAA;
        step();
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (count == N) begin
      check("sort_in_ready", in_ready, 0);
      check("sort_out_valid", out_valid, 0);
      check("sort_out_data", out_data, 0);
      step();
      check("latency_out_valid", out_valid, 1);
      $display("load: %0d elements, gaps=%0d, out_valid two edges after last input", count, gaps);
    end
  endtask

  task automatic drain_frame(input int count, input bit toggle);
    for (int i = 0; i < count; i++) begin
      if (toggle && (i % 2 == 1)) begin
        out_ready = 1'b0;
        step();
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, exp_vec[i]);
        check("stall_out_last", out_last, (i == N - 1));
      end
      out_ready = 1'b1;
      check("drain_out_valid", out_valid, 1);
      check("drain_in_ready", in_ready, 0);
      check("drain_out_data", out_data, exp_vec[i]);
      check("drain_out_last", out_last, (i == N - 1));
      step();
    end
    out_ready = 1'b0;
    $display("drain: %0d transfers, toggle=%0d", count, toggle);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_frame_cnt"}, frame_cnt, exp_fc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_fc = 0;
  endtask

  initial begin
    logic [W-1:0] t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Descending input 16..1 -> 1..16
    for (int i = 0; i < N; i++) begin
      vec[i]     = 8'(16 - i);
      exp_vec[i] = 8'(i + 1);
    end
    load_frame(N, 1'b0);
    drain_frame(N, 1'b0);
    exp_fc = 1;
    check_idle("frame1");

    // Duplicates l%8 -> 0,0,1,1,...,7,7
    for (int i = 0; i < N; i++) begin
      vec[i]     = 8'(i % 8);
      exp_vec[i] = 8'(i / 2);
    end
    load_frame(N, 1'b0);
    drain_frame(N, 1'b0);
    exp_fc = 2;
    check_idle("frame2");

    // Input gaps and output back-pressure
    for (int i = 0; i < N; i++) begin
      vec[i]     = 8'(i);
      exp_vec[i] = 8'(i);
    end
    load_frame(N, 1'b1);
    drain_frame(N, 1'b1);
    exp_fc = 3;
    check_idle("frame3");

    // Random frames against a bench-side sort
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        vec[i]     = 8'($urandom_range(0, 255));
        exp_vec[i] = vec[i];
      end
      for (int a = 0; a < N - 1; a++) begin
        for (int b = 0; b < N - 1 - a; b++) begin
          if (exp_vec[b] > exp_vec[b+1]) begin
            t            = exp_vec[b];
            exp_vec[b]   = exp_vec[b+1];
            exp_vec[b+1] = t;
          end
        end
      end
      load_frame(N, 1'b0);
      drain_frame(N, (f % 2) == 1);
      exp_fc++;
      check("rand_frame_cnt", frame_cnt, exp_fc);
    end
    check_idle("rand_done");

    // frame_cnt wrap
    force dut.frame_cnt_reg = 16'hFFFF;
    step();
    release dut.frame_cnt_reg;
    check("preload_frame_cnt", frame_cnt, 16'hFFFF);
    load_frame(N, 1'b0);
    drain_frame(N, 1'b0);
    exp_fc = 0;
    check_idle("wrap");
    $display("wrap: frame_cnt=%0h", frame_cnt);

    // Reset after 7 elements loaded, then a fresh frame
    for (int i = 0; i < N; i++) begin
      vec[i] = 8'hF0 + 8'(i);
    end
    load_frame(7, 1'b0);
    do_reset();
    check_idle("midload_reset");
    for (int i = 0; i < N; i++) begin
      vec[i]     = 8'(((i * 7) % 16) + 16);
      exp_vec[i] = 8'(i + 16);
    end
    load_frame(N, 1'b0);
    drain_frame(N, 1'b0);
    exp_fc = 1;
    check_idle("after_midload");

    // Reset in DRAIN after 5 transfers
    load_frame(N, 1'b0);
    drain_frame(5, 1'b0);
    out_ready = 1'b1;
    do_reset();
    check_idle("middrain_reset");
    step();
    check("middrain_out_valid_hold", out_valid, 0);
    out_ready = 1'b0;
    $display("mid-drain reset: out_valid=%0d frame_cnt=%0d", out_valid, frame_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
